// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the PD4 hazard controller: forwarding selects, match
// flavours for the hazard comparator, and the forwarding priority helper.
package hazard_ctrl_pkg;

    // E-stage operand source selects
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Which producer property qualifies a register-index hit
    typedef enum logic [1:0] {
        MATCH_ANY_WRITE = 2'd0,  // any register write (WB-stage forwarding)
        MATCH_ALU_WRITE = 2'd1,  // register write whose data is ready (not a load)
        MATCH_LOAD      = 2'd2   // load whose data is not yet available
    } match_kind_e;

    // The youngest producer wins: MEM before WB
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_MEM;
        if (wb_hit)  return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does an in-flight shadow entry produce the
// register named by idx? x0 never matches.
module hazard_match
    import hazard_ctrl_pkg::*;
#(
    parameter int          AWIDTH = 5,
    parameter match_kind_e KIND   = MATCH_ANY_WRITE
) (
    input  logic              valid,
    input  logic              regwren,
    input  logic              memren,
    input  logic [AWIDTH-1:0] rd,
    input  logic [AWIDTH-1:0] idx,
    output logic              hit
);

    logic qual;

    // Select the producer qualifier for this comparator flavour
    always_comb begin
        case (KIND)
            MATCH_ALU_WRITE: qual = regwren & ~memren;
            MATCH_LOAD:      qual = memren;
            default:         qual = regwren;
        endcase
    end

    assign hit = valid & qual & (rd != '0) & (rd == idx);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core. Keeps a shadow copy of
// the destination registers held in E, M and W, and from it derives
// load-use stalls, redirect flushes, memory freezes and E-stage forwarding.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid_i,
    input  logic [AWIDTH-1:0] d_rs1_i,
    input  logic [AWIDTH-1:0] d_rs2_i,
    input  logic              d_rs1_used_i,
    input  logic              d_rs2_used_i,
    input  logic [AWIDTH-1:0] d_rd_i,
    input  logic              d_regwren_i,
    input  logic              d_memren_i,
    input  logic              e_br_taken_i,
    input  logic              mem_busy_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              bubble_e_o,
    output logic              flush_d_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              freeze_o,
    output logic [CWIDTH-1:0] stall_cnt_o,
    output logic [CWIDTH-1:0] flush_cnt_o
);

    // E keeps its source indices so forwarding can be resolved there
    typedef struct packed {
        logic              valid;
        logic [AWIDTH-1:0] rs1;
        logic [AWIDTH-1:0] rs2;
        logic [AWIDTH-1:0] rd;
        logic              regwren;
        logic              memren;
    } e_entry_t;

    typedef struct packed {
        logic              valid;
        logic [AWIDTH-1:0] rd;
        logic              regwren;
        logic              memren;
    } mw_entry_t;

    e_entry_t  e_q, e_d;
    mw_entry_t m_q, w_q;

    logic lu_rs1_hit, lu_rs2_hit, load_use;
    logic a_mem_hit, a_wb_hit, b_mem_hit, b_wb_hit;
    logic stall_inc, flush_inc;
    logic [CWIDTH-1:0] stall_cnt_q, flush_cnt_q;

    // Load in E whose result the instruction in D needs next cycle
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_LOAD)) u_lu_rs1 (
        .valid(e_q.valid), .regwren(e_q.regwren), .memren(e_q.memren),
        .rd(e_q.rd), .idx(d_rs1_i), .hit(lu_rs1_hit)
    );
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_LOAD)) u_lu_rs2 (
        .valid(e_q.valid), .regwren(e_q.regwren), .memren(e_q.memren),
        .rd(e_q.rd), .idx(d_rs2_i), .hit(lu_rs2_hit)
    );

    assign load_use = d_valid_i & ((d_rs1_used_i & lu_rs1_hit) |
                                   (d_rs2_used_i & lu_rs2_hit));

    // Forwarding sources for operand A; a load in M has no data yet
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_ALU_WRITE)) u_a_mem (
        .valid(m_q.valid), .regwren(m_q.regwren), .memren(m_q.memren),
        .rd(m_q.rd), .idx(e_q.rs1), .hit(a_mem_hit)
    );
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_ANY_WRITE)) u_a_wb (
        .valid(w_q.valid), .regwren(w_q.regwren), .memren(w_q.memren),
        .rd(w_q.rd), .idx(e_q.rs1), .hit(a_wb_hit)
    );

    // Forwarding sources for operand B
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_ALU_WRITE)) u_b_mem (
        .valid(m_q.valid), .regwren(m_q.regwren), .memren(m_q.memren),
        .rd(m_q.rd), .idx(e_q.rs2), .hit(b_mem_hit)
    );
    hazard_match #(.AWIDTH(AWIDTH), .KIND(MATCH_ANY_WRITE)) u_b_wb (
        .valid(w_q.valid), .regwren(w_q.regwren), .memren(w_q.memren),
        .rd(w_q.rd), .idx(e_q.rs2), .hit(b_wb_hit)
    );

    assign fwd_a_o = e_q.valid ? fwd_pick(a_mem_hit, a_wb_hit) : FWD_NONE;
    assign fwd_b_o = e_q.valid ? fwd_pick(b_mem_hit, b_wb_hit) : FWD_NONE;

    // Prioritised pipeline controls: freeze, then redirect, then load-use
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        freeze_o   = 1'b0;
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        bubble_e_o = 1'b0;
        flush_d_o  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (mem_busy_i) begin
            freeze_o  = 1'b1;
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
        end else if (e_br_taken_i) begin
            // the dependent in D is squashed, so a load-use here is moot
            flush_d_o  = 1'b1;
            bubble_e_o = 1'b1;
            flush_inc  = 1'b1;
        end else if (load_use) begin
            stall_f_o  = 1'b1;
            stall_d_o  = 1'b1;
            bubble_e_o = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    // Next E entry: the decoded instruction, or an empty bubble
    always_comb begin
        e_d = '0;
        if (!bubble_e_o) begin
            e_d.valid   = d_valid_i;
            e_d.rs1     = d_rs1_i;
            e_d.rs2     = d_rs2_i;
            e_d.rd      = d_rd_i;
            e_d.regwren = d_regwren_i;
            e_d.memren  = d_memren_i;
        end
    end

    // Shadow pipeline advances with the real one and holds while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!freeze_o) begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            w_q         <= m_q;
            m_q.valid   <= e_q.valid;
            m_q.rd      <= e_q.rd;
            m_q.regwren <= e_q.regwren;
            m_q.memren  <= e_q.memren;
            e_q         <= e_d;
        end
    end

    // Saturating debug counters; frozen cycles never count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CWIDTH'(1);
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CWIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the in-flight instruction window.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int CWS = 4;   // narrow counters on a second instance to reach saturation

    logic clk = 1'b0;
    logic rst_n;
    logic          d_valid_i, d_rs1_used_i, d_rs2_used_i, d_regwren_i, d_memren_i;
    logic [AW-1:0] d_rs1_i, d_rs2_i, d_rd_i;
    logic          e_br_taken_i, mem_busy_i;

    logic          stall_f_o, stall_d_o, bubble_e_o, flush_d_o, freeze_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    logic           s_stall_f, s_stall_d, s_bubble_e, s_flush_d, s_freeze;
    logic [1:0]     s_fwd_a, s_fwd_b;
    logic [CWS-1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
        .d_rs1_used_i(d_rs1_used_i), .d_rs2_used_i(d_rs2_used_i),
        .d_rd_i(d_rd_i), .d_regwren_i(d_regwren_i), .d_memren_i(d_memren_i),
        .e_br_taken_i(e_br_taken_i), .mem_busy_i(mem_busy_i),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .bubble_e_o(bubble_e_o),
        .flush_d_o(flush_d_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .freeze_o(freeze_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_ctrl #(.AWIDTH(AW), .CWIDTH(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
        .d_rs1_used_i(d_rs1_used_i), .d_rs2_used_i(d_rs2_used_i),
        .d_rd_i(d_rd_i), .d_regwren_i(d_regwren_i), .d_memren_i(d_memren_i),
        .e_br_taken_i(e_br_taken_i), .mem_busy_i(mem_busy_i),
        .stall_f_o(s_stall_f), .stall_d_o(s_stall_d), .bubble_e_o(s_bubble_e),
        .flush_d_o(s_flush_d), .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b),
        .freeze_o(s_freeze), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    // ---------------- behavioural model ----------------
    // pipe[0]=E, pipe[1]=M, pipe[2]=W: the instructions currently in flight
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit wr;
        bit ld;
    } ins_t;

    ins_t pipe[3];
    int   n_stall, n_flush;
    int   vectors, miscompares;
    bit   last_hold;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pipe[i].v = 0; pipe[i].rs1 = 0; pipe[i].rs2 = 0;
            pipe[i].rd = 0; pipe[i].wr = 0; pipe[i].ld = 0;
        end
        n_stall   = 0;
        n_flush   = 0;
        last_hold = 0;
    endtask

    // The decoded instruction needs a register a load in E has not fetched yet
    function automatic bit model_load_use();
        bit need1, need2;
        if (!(pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && d_valid_i)) return 0;
        need1 = d_rs1_used_i && (int'(d_rs1_i) == pipe[0].rd);
        need2 = d_rs2_used_i && (int'(d_rs2_i) == pipe[0].rd);
        return need1 || need2;
    endfunction

    // Walk older instructions from youngest to oldest; the first one able to
    // supply register r wins. A load in M cannot supply yet, so look past it.
    function automatic int model_fwd(input int r);
        if (!pipe[0].v || r == 0) return 0;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].v && pipe[s].wr && pipe[s].rd == r && !(s == 1 && pipe[s].ld))
                return (s == 1) ? int'(FWD_MEM) : int'(FWD_WB);
        end
        return int'(FWD_NONE);
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit dv, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit wr, input bit ld, input bit br, input bit busy);
        d_valid_i    = dv;
        d_rs1_i      = rs1[AW-1:0];
        d_rs2_i      = rs2[AW-1:0];
        d_rs1_used_i = u1;
        d_rs2_used_i = u2;
        d_rd_i       = rd[AW-1:0];
        d_regwren_i  = wr;
        d_memren_i   = ld;
        e_br_taken_i = br;
        mem_busy_i   = busy;
    endtask

    task automatic nop(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    // Compare one cycle on the falling edge, then advance the model as the
    // pipeline will on the next rising edge.
    task automatic step();
        bit lu, busy, br, e_freeze, e_flush, e_bub, e_stall;
        @(negedge clk);
        busy     = mem_busy_i;
        br       = e_br_taken_i;
        lu       = model_load_use();
        e_freeze = busy;
        e_flush  = !busy && br;
        e_bub    = !busy && (br || lu);
        e_stall  = busy || (!br && lu);
        check("freeze",     freeze_o,    e_freeze);
        check("stall_f",    stall_f_o,   e_stall);
        check("stall_d",    stall_d_o,   e_stall);
        check("bubble_e",   bubble_e_o,  e_bub);
        check("flush_d",    flush_d_o,   e_flush);
        check("fwd_a",      fwd_a_o,     model_fwd(pipe[0].rs1));
        check("fwd_b",      fwd_b_o,     model_fwd(pipe[0].rs2));
        check("stall_cnt",  stall_cnt_o, sat(n_stall, CW));
        check("flush_cnt",  flush_cnt_o, sat(n_flush, CW));
        check("s_bubble_e", s_bubble_e,  e_bub);
        check("s_stall_cnt", s_stall_cnt, sat(n_stall, CWS));
        check("s_flush_cnt", s_flush_cnt, sat(n_flush, CWS));
        last_hold = e_stall;
        if (!busy) begin
            n_flush += int'(br);
            n_stall += int'(!br && lu);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_bub || !d_valid_i) begin
                pipe[0].v = 0; pipe[0].rs1 = 0; pipe[0].rs2 = 0;
                pipe[0].rd = 0; pipe[0].wr = 0; pipe[0].ld = 0;
                if (!e_bub) begin
                    pipe[0].rs1 = int'(d_rs1_i);
                    pipe[0].rs2 = int'(d_rs2_i);
                end
            end else begin
                pipe[0].v   = 1;
                pipe[0].rs1 = int'(d_rs1_i);
                pipe[0].rs2 = int'(d_rs2_i);
                pipe[0].rd  = int'(d_rd_i);
                pipe[0].wr  = d_regwren_i;
                pipe[0].ld  = d_memren_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random traffic over a few registers so hazards are frequent; a stalled
    // decode keeps its instruction and a branch stays asserted through a freeze.
    task automatic rand_cycle();
        bit busy, br;
        busy = ($urandom_range(0, 99) < 15);
        br   = (mem_busy_i && e_br_taken_i) ? 1'b1 : ($urandom_range(0, 99) < 12);
        if (last_hold) begin
            e_br_taken_i = br;
            mem_busy_i   = busy;
        end else begin
            drive($urandom_range(0, 99) < 85,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
                  br, busy);
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        nop();
        model_reset();

        // reset state
        #2;
        check("rst_freeze",    freeze_o,    0);
        check("rst_stall_f",   stall_f_o,   0);
        check("rst_bubble_e",  bubble_e_o,  0);
        check("rst_fwd_a",     fwd_a_o,     FWD_NONE);
        check("rst_stall_cnt", stall_cnt_o, 0);
        check("rst_flush_cnt", flush_cnt_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw x5 in E, add x6,x5,x7 in D: exactly one stall, then WB forwarding
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); step();
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
        #2;
        check("lu_stall_f",  stall_f_o,   1);
        check("lu_stall_d",  stall_d_o,   1);
        check("lu_bubble_e", bubble_e_o,  1);
        check("lu_cnt_pre",  stall_cnt_o, 0);
        step();
        #2;
        check("lu_one_cycle", stall_f_o,  0);
        check("lu_cnt_post", stall_cnt_o, 1);
        step();
        nop();
        #2;
        check("lu_fwd_wb",   fwd_a_o,     FWD_WB);
        step();

        // addi x5 in W, add x5 in M, sub reading x5 in E: MEM wins; x0 never forwards
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        drive(1, 5, 9, 1, 1, 10, 1, 0, 0, 0); step();
        nop();
        #2;
        check("prio_fwd_a_mem", fwd_a_o, FWD_MEM);
        check("prio_fwd_b_none", fwd_b_o, FWD_NONE);
        step();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 0, 0, 1, 1, 10, 1, 0, 0, 0); step();
        nop();
        #2;
        check("x0_fwd_a", fwd_a_o, FWD_NONE);
        check("x0_fwd_b", fwd_b_o, FWD_NONE);
        step();

        // branch redirect with a concurrent load-use: flush wins
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); step();
        drive(1, 5, 7, 1, 1, 6, 1, 0, 1, 0);
        #2;
        check("br_flush_d",  flush_d_o,  1);
        check("br_bubble_e", bubble_e_o, 1);
        check("br_stall_f",  stall_f_o,  0);
        step();
        nop();
        #2;
        check("br_flush_cnt", flush_cnt_o, 1);
        check("br_stall_cnt", stall_cnt_o, 0);
        step();

        // three-cycle memory freeze over a load-use, then a single stall
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 7, 1, 1, 6, 1, 0, 0, 1);
            #2;
            check("frz_freeze", freeze_o,    1);
            check("frz_cnt",    stall_cnt_o, 0);
            step();
        end
        drive(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
        #2;
        check("frz_then_stall", stall_f_o, 1);
        check("frz_released",   freeze_o,  0);
        step();
        #2;
        check("frz_single_stall", stall_f_o,   0);
        check("frz_cnt_after",    stall_cnt_o, 1);
        step();

        // back-to-back lw x5,0(x5): a stall every other cycle, 20 in 40 cycles
        do_reset();
        drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        for (int i = 0; i < 40; i++) step();
        nop();
        #2;
        check("sat_wide_cnt",   stall_cnt_o, 20);
        check("sat_narrow_cnt", s_stall_cnt, 15);
        step();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) rand_cycle();

        // asynchronous reset while M holds a register writer
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0); step();
        nop();
        #2;
        check("mid_fwd_before", fwd_a_o, FWD_MEM);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fwd_a",     fwd_a_o,     FWD_NONE);
        check("mid_rst_stall_cnt", stall_cnt_o, 0);
        check("mid_rst_flush_cnt", flush_cnt_o, 0);
        check("mid_rst_s_flush",   s_flush_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the PD4 five-stage RISC-V core (F/D/E/M/W).
- Tracks in-flight destination registers for E, M and W in its own shadow pipeline, fed by decode/control outputs.
- Generates stall, bubble and flush controls, plus E-stage operand forwarding selects.
- Freezes the whole pipeline while data memory is busy, and keeps saturating stall/flush counters for debug.

Parameters:
- AWIDTH, 5, register-index width.
- CWIDTH, 16, width of each perf counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- d_valid_i  in  1  decode stage holds a valid instruction
- d_rs1_i  in  AWIDTH  decode rs1 index
- d_rs2_i  in  AWIDTH  decode rs2 index
- d_rs1_used_i  in  1  instruction reads rs1
- d_rs2_used_i  in  1  instruction reads rs2
- d_rd_i  in  AWIDTH  decode rd index
- d_regwren_i  in  1  regwren from control
- d_memren_i  in  1  memren from control (load)
- e_br_taken_i  in  1  E-stage branch/jump resolved to redirect PC
- mem_busy_i  in  1  data memory not ready, freeze request
- stall_f_o  out  1  hold PC
- stall_d_o  out  1  hold F/D register
- bubble_e_o  out  1  load a NOP into D/E register
- flush_d_o  out  1  squash F/D register
- fwd_a_o  out  2  E operand A source
- fwd_b_o  out  2  E operand B source
- freeze_o  out  1  hold every pipeline register
- stall_cnt_o  out  CWIDTH  load-use stall cycles, saturating
- flush_cnt_o  out  CWIDTH  redirect flushes, saturating

Behaviour:
- Reset (rst_n=0, async):
  - All shadow entries are invalid: valid=0, rd=0, regwren=0, memren=0, rs=0.
  - Both counters are 0. All outputs are 0; fwd = FWD_NONE.
- Shadow pipeline:
  - E entry {valid, rs1, rs2, rd, regwren, memren}; M and W entries {valid, rd, regwren, memren}.
  - On each rising edge with freeze_o=0: W<=M, M<=E, and E<=D.
  - E loads an invalid bubble instead of D when bubble_e_o=1.
- load_use (combinational) = E.valid & E.memren & E.rd!=0 & d_valid_i & ((d_rs1_used_i & d_rs1_i==E.rd) | (d_rs2_used_i & d_rs2_i==E.rd)).
- Priority, highest first:
  1. mem_busy_i: freeze_o=1, stall_f_o=1, stall_d_o=1, bubble_e_o=0, flush_d_o=0. Shadow and counters hold. e_br_taken_i must be held by the source until the freeze ends.
  2. e_br_taken_i: flush_d_o=1, bubble_e_o=1, stall outputs 0. Any concurrent load_use is ignored because the consumer is squashed. flush_cnt increments.
  3. load_use: stall_f_o=1, stall_d_o=1, bubble_e_o=1. stall_cnt increments. Exactly one stall cycle per load-use, since the load then sits in M and the dependent in D reaches E as the load reaches W.
  4. Otherwise all controls are 0.
- Forwarding (combinational, per E operand, for an operand index r):
  - FWD_MEM when M.valid & M.regwren & !M.memren & M.rd!=0 & M.rd==r.
  - Else FWD_WB when W.valid & W.regwren & W.rd!=0 & W.rd==r.
  - Else FWD_NONE.
  - MEM has priority over WB (youngest producer wins). x0 never forwards.
  - fwd outputs are forced to FWD_NONE when E.valid=0.
- Counters: saturate at all-ones with no wrap; they increment only on non-frozen cycles.
- Reset mid-operation clears everything immediately; the first cycle after release behaves as an empty pipeline.
- Latency: every control output is combinational from inputs and shadow state in the same cycle; the shadow state updates one edge later.

Decomposition:
- constants.svh:
  - fwd_sel_e enum: FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - A shadow-entry struct typedef.
- One sub-module, hazard_match (combinational): given an entry and a register index, returns hit under the valid/regwren/rd!=0 rules. It is instantiated for both the forwarding checks and load_use.

Test Plan:
- lw x5 in E, add x6,x5,x7 in D -> one cycle of stall_f/stall_d/bubble_e=1, stall_cnt 0->1; next cycle fwd_a=FWD_WB.
- add x5 in M and addi x5 in W, sub in E reading rs1=x5 -> fwd_a=FWD_MEM (priority). Repeat with rd=x0 -> FWD_NONE.
- lw x5 in E and e_br_taken_i=1 same cycle with a dependent in D -> flush_d=1, bubble_e=1, stall_f=0, flush_cnt=1, stall_cnt unchanged.
- mem_busy_i=1 for 3 cycles during load-use -> freeze_o=1 for all 3, counters constant, shadow unchanged; after release a single stall cycle occurs.
- Force stall_cnt to 16'hFFFF then a load-use -> stays 16'hFFFF.
- Drop rst_n mid-stream with M.regwren=1 -> fwd=FWD_NONE, counters 0 asynchronously, before the next clock edge.
